// File: rtl/max30003_spi_arbiter.sv
// Shares one spi_master between the MAX30003 init, ECG FIFO and RTOR requesters: one 32-bit transaction at a time,
// watchdog on spi_done, chip-select idle gap. Define MAX30003_ARB_RR_EN for round-robin instead of fixed priority.
module max30003_spi_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  req_tx,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_data,
   output logic                   rsp_err,
   output logic                   spi_start,
   output logic [31:0]            spi_tx,
   input  logic [31:0]            spi_rx,
   input  logic                   spi_done,
   output logic                   busy
);

   localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

   state_t             state_reg;
   logic [WD_W-1:0]    wd_reg;
   logic [WD_W-1:0]    wd_next;
   logic [GAP_W-1:0]   gap_reg;
   logic [IDX_W-1:0]   win;
   logic [NUM_REQ-1:0] win_onehot;
   logic [31:0]        win_tx;

`ifdef MAX30003_ARB_RR_EN
   logic [IDX_W-1:0]   ptr_reg;
   logic [IDX_W-1:0]   ptr_next;
   logic               found;
   int                 rr_idx;

   // Search starts at the pointer and wraps, so the last winner has lowest priority.
   always_comb begin
      win    = '0;
      found  = 1'b0;
      rr_idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rr_idx = (int'(ptr_reg) + k) % NUM_REQ;
         if (!found && req[rr_idx]) begin
            win   = IDX_W'(rr_idx);
            found = 1'b1;
         end
      end
   end

   assign ptr_next = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
`else
   always_comb begin
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) win = IDX_W'(i);
      end
   end
`endif

   always_comb begin
      win_onehot = '0;
      win_tx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_onehot[i] = (win == IDX_W'(i));
         if (win == IDX_W'(i)) win_tx = req_tx[32*i +: 32];
      end
   end

   assign wd_next = wd_reg + WD_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         wd_reg    <= '0;
         gap_reg   <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         spi_start <= 1'b0;
         spi_tx    <= '0;
         busy      <= 1'b0;
`ifdef MAX30003_ARB_RR_EN
         ptr_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (|req) begin
                  gnt       <= win_onehot;
                  spi_tx    <= win_tx;
                  spi_start <= 1'b1;
                  busy      <= 1'b1;
                  state_reg <= ISSUE;
`ifdef MAX30003_ARB_RR_EN
                  ptr_reg   <= ptr_next;
`endif
               end
            end
            ISSUE: begin
               spi_start <= 1'b0;
               wd_reg    <= '0;
               state_reg <= WAIT;
            end
            WAIT: begin
               // A completion on the expiry cycle still counts as success.
               if (spi_done) begin
                  rsp_data  <= spi_rx;
                  rsp_err   <= 1'b0;
                  rsp_valid <= gnt;
                  state_reg <= RESP;
               end else if (wd_next == WD_W'(TIMEOUT_CYCLES)) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= gnt;
                  state_reg <= RESP;
               end else begin
                  wd_reg <= wd_next;
               end
            end
            RESP: begin
               gnt       <= '0;
               rsp_valid <= '0;
               rsp_err   <= 1'b0;
               gap_reg   <= '0;
               if (GAP_CYCLES == 0) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  state_reg <= GAP;
               end
            end
            GAP: begin
               if (gap_reg == GAP_W'(GAP_LAST)) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  gap_reg <= gap_reg + GAP_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max30003_spi_arbiter.sv
// Scoreboard bench for max30003_spi_arbiter: directed requests push expected grants/responses, monitors pop and compare.
module tb_max30003_spi_arbiter;

   localparam int NUM_REQ        = 3;
   localparam int GAP_CYCLES     = 4;
   localparam int TIMEOUT_CYCLES = 4096;

   logic         clk;
   logic         rst;
   logic [2:0]   req;
   logic [95:0]  req_tx;
   logic [2:0]   gnt;
   logic [2:0]   rsp_valid;
   logic [31:0]  rsp_data;
   logic         rsp_err;
   logic         spi_start;
   logic [31:0]  spi_tx;
   logic [31:0]  spi_rx;
   logic         spi_done;
   logic         busy;

   typedef struct packed { logic [2:0] g; logic [31:0] tx; } gnt_t;
   typedef struct packed { logic [2:0] v; logic [31:0] d; logic e; } rsp_t;

   gnt_t gnt_q[$];
   rsp_t rsp_q[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int last_gnt_cyc = -1;
   int last_rsp_cyc = -1;

   bit          model_en = 1'b0;
   int          model_delay = 40;
   logic [31:0] model_rx = '0;
   int          stray_req = 0;
   int          stray_seen = 0;

   max30003_spi_arbiter #(
      .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_tx(req_tx), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .spi_start(spi_start), .spi_tx(spi_tx),
      .spi_rx(spi_rx), .spi_done(spi_done), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // spi_master model: spi_done is sampled model_delay edges after the grant edge.
   initial begin
      spi_done = 1'b0;
      spi_rx   = '0;
      forever begin
         @(posedge clk); #1;
         if (stray_req != stray_seen) begin
            stray_seen++;
            spi_rx = 32'hDEADBEEF; spi_done = 1'b1;
            @(posedge clk); #1;
            spi_done = 1'b0;
         end else if (spi_start === 1'b1 && model_en) begin
            repeat (model_delay - 1) @(posedge clk);
            #1;
            spi_rx = model_rx; spi_done = 1'b1;
            @(posedge clk); #1;
            spi_done = 1'b0;
         end
      end
   end

   // Grant monitor
   initial forever begin
      gnt_t e;
      @(negedge clk);
      if (rst === 1'b1 && spi_start === 1'b1) begin
         if (gnt_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_grant: gnt=%b spi_tx=0x%h, expected no grant", gnt, spi_tx);
         end else begin
            e = gnt_q.pop_front();
            check("gnt", 64'(gnt), 64'(e.g));
            check("spi_tx", 64'(spi_tx), 64'(e.tx));
            if (last_gnt_cyc >= 0)
               check("gnt_spacing_ok", 64'(cyc - last_gnt_cyc >= GAP_CYCLES + 2), 64'd1);
         end
         last_gnt_cyc = cyc;
      end
   end

   // Response monitor
   initial forever begin
      rsp_t e;
      @(negedge clk);
      if (rst === 1'b1 && rsp_valid !== 3'b000) begin
         if (rsp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rsp: rsp_valid=%b data=0x%h err=%b, expected no response",
                     rsp_valid, rsp_data, rsp_err);
         end else begin
            e = rsp_q.pop_front();
            check("rsp_valid", 64'(rsp_valid), 64'(e.v));
            check("rsp_data", 64'(rsp_data), 64'(e.d));
            check("rsp_err", 64'(rsp_err), 64'(e.e));
            check("gnt_held", 64'(gnt), 64'(e.v));
         end
         last_rsp_cyc = cyc;
      end
   end

   task automatic wait_gnt(input string name, input int max);
      int n = 0;
      while (gnt_q.size() != 0 && n < max) begin @(negedge clk); n++; end
      check(name, 64'(gnt_q.size() == 0), 64'd1);
   endtask

   task automatic wait_drain(input string name, input int max);
      int n = 0;
      while ((gnt_q.size() != 0 || rsp_q.size() != 0) && n < max) begin @(negedge clk); n++; end
      check(name, 64'(gnt_q.size() == 0 && rsp_q.size() == 0), 64'd1);
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < max) begin @(negedge clk); n++; end
      check(name, 64'(busy), 64'd0);
   endtask

   initial begin
      int order[4];
      rst = 1'b0; req = '0; req_tx = '0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({gnt, rsp_valid, rsp_err, spi_start, busy}), 64'd0);
      check("reset_data", {rsp_data, spi_tx}, 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Contention with all three requesters held
`ifdef MAX30003_ARB_RR_EN
      order = '{0, 1, 2, 0};
`else
      order = '{0, 0, 0, 0};
`endif
      req_tx = {32'hA2222222, 32'hA1111111, 32'hA0000000};
      model_en = 1'b1; model_delay = 5; model_rx = 32'h5555AAAA;
      for (int k = 0; k < 4; k++) begin
         gnt_q.push_back('{g: 3'(1 << order[k]), tx: req_tx[32*order[k] +: 32]});
         rsp_q.push_back('{v: 3'(1 << order[k]), d: 32'h5555AAAA, e: 1'b0});
      end
      req = 3'b111;
      wait_drain("contention_drain", 200);
      req = 3'b000;
      wait_idle("contention_idle", 50);

      // Single transaction on requester 1
      req_tx = {32'h0, 32'h21FFFFFF, 32'h0};
      model_delay = 40; model_rx = 32'h00ABCDEF;
      gnt_q.push_back('{g: 3'b010, tx: 32'h21FFFFFF});
      rsp_q.push_back('{v: 3'b010, d: 32'h00ABCDEF, e: 1'b0});
      req = 3'b010;
      wait_gnt("single_gnt", 20);
      req = 3'b000;
      wait_drain("single_drain", 100);
      check("single_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'd40);
      wait_idle("single_idle", 50);

      // Timeout: spi_done never arrives
      model_en = 1'b0;
      req_tx = {32'h30000002, 64'h0};
      gnt_q.push_back('{g: 3'b100, tx: 32'h30000002});
      rsp_q.push_back('{v: 3'b100, d: 32'h0, e: 1'b1});
      req = 3'b100;
      wait_gnt("timeout_gnt", 20);
      req = 3'b000;
      wait_drain("timeout_drain", TIMEOUT_CYCLES + 100);
      check("timeout_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'(TIMEOUT_CYCLES + 1));
      wait_idle("timeout_idle", 50);

      // spi_done on the very cycle the watchdog expires
      model_en = 1'b1; model_delay = TIMEOUT_CYCLES + 1; model_rx = 32'h0BADC0DE;
      gnt_q.push_back('{g: 3'b100, tx: 32'h30000002});
      rsp_q.push_back('{v: 3'b100, d: 32'h0BADC0DE, e: 1'b0});
      req = 3'b100;
      wait_gnt("boundary_gnt", 20);
      req = 3'b000;
      wait_drain("boundary_drain", TIMEOUT_CYCLES + 100);
      check("boundary_latency", 64'(last_rsp_cyc - last_gnt_cyc), 64'(TIMEOUT_CYCLES + 1));
      wait_idle("boundary_idle", 50);

      // Stray spi_done while idle
      stray_req++;
      repeat (4) @(negedge clk);
      check("stray_busy", 64'(busy), 64'd0);
      check("stray_gnt", 64'(gnt), 64'd0);

      // Request dropped right after grant
      req_tx = {64'h0, 32'h0F0F0F0F};
      model_delay = 10; model_rx = 32'h12345678;
      gnt_q.push_back('{g: 3'b001, tx: 32'h0F0F0F0F});
      rsp_q.push_back('{v: 3'b001, d: 32'h12345678, e: 1'b0});
      req = 3'b001;
      wait_gnt("drop_gnt", 20);
      req = 3'b000;
      wait_drain("drop_drain", 100);
      wait_idle("drop_idle", 50);

      // Reset during WAIT
      model_en = 1'b0;
      req_tx = {64'h0, 32'h77777777};
      gnt_q.push_back('{g: 3'b001, tx: 32'h77777777});
      req = 3'b001;
      wait_gnt("rst_gnt", 20);
      req = 3'b000;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_ctrl_now", 64'({gnt, rsp_valid, rsp_err, spi_start, busy}), 64'd0);
      @(negedge clk);
      check("midrst_ctrl", 64'({gnt, rsp_valid, rsp_err, spi_start, busy}), 64'd0);
      check("midrst_data", {rsp_data, spi_tx}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      req_tx = {32'h0, 32'h21FFFFFF, 32'h0};
      model_en = 1'b1; model_delay = 6; model_rx = 32'h600D600D;
      gnt_q.push_back('{g: 3'b010, tx: 32'h21FFFFFF});
      rsp_q.push_back('{v: 3'b010, d: 32'h600D600D, e: 1'b0});
      req = 3'b010;
      wait_gnt("after_rst_gnt", 20);
      req = 3'b000;
      wait_drain("after_rst_drain", 100);
      wait_idle("after_rst_idle", 50);

      repeat (5) @(negedge clk);
      check("queues_empty", 64'(gnt_q.size() + rsp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/max30003_spi_arbiter.md
# max30003_spi_arbiter

Shares the single `spi_master` instance between the ECG front-end's SPI users: init sequencer, ECG FIFO reader, RTOR reader. Each user sees a request/grant/response port. The arbiter grants one 32-bit transaction at a time, drives the start pulse, and waits for `spi_done` under a watchdog. It then returns the received word and enforces a chip-select idle gap before the next grant. It sits between the MAX30003 driver logic and `spi_master`.

## Interface
- `NUM_REQ`, 3: number of requesters. Index 0 is init, 1 is ECG FIFO, 2 is RTOR.
- `GAP_CYCLES`, 4: idle cycles inserted between transactions. 0 means no gap.
- `TIMEOUT_CYCLES`, 4096: WAIT cycles allowed before a transaction is aborted. Must be ≥1.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  request level per requester
- `req_tx`  in  32*NUM_REQ  transmit words; requester i uses bits [32*i+31:32*i]
- `gnt`  out  NUM_REQ  one-hot grant, held from issue through response
- `rsp_valid`  out  NUM_REQ  one-cycle response pulse to the granted requester
- `rsp_data`  out  32  received word, valid with `rsp_valid`
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`
- `spi_start`  out  1  one-cycle start pulse to `spi_master`
- `spi_tx`  out  32  word to `spi_master`, stable from issue to response
- `spi_rx`  in  32  word from `spi_master`
- `spi_done`  in  1  transaction-complete pulse from `spi_master`
- `busy`  out  1  high in every state except IDLE

## Operation
- **Reset values:** all outputs are 0, state is IDLE, watchdog and gap counters are 0, round-robin pointer is 0.
- **States:** IDLE, ISSUE, WAIT, RESP, GAP.
- **IDLE:** if any `req` bit is set, pick a winner, set its `gnt` bit, latch its `req_tx` slice into `spi_tx`, set `spi_start`, and go to ISSUE. Requests are sampled only in IDLE.
- **ISSUE:** clear `spi_start`, clear the watchdog, go to WAIT.
- **WAIT:**
  - On `spi_done`: capture `spi_rx` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT_CYCLES: set `rsp_data`=0, set `rsp_err`=1, go to RESP.
  - If `spi_done` and the timeout land on the same cycle, `spi_done` wins.
- **RESP:** `rsp_valid[winner]` is high for this one cycle. On leaving RESP, clear `gnt`, `rsp_valid` and `rsp_err`. Go to GAP, or straight to IDLE if GAP_CYCLES=0.
- **GAP:** count GAP_CYCLES cycles, then go to IDLE.
- **Other rules:**
  - `spi_done` outside WAIT is ignored.
  - Dropping `req` after grant does not abort: the transaction completes and the response is still delivered.
  - A requester that holds `req` after its response is eligible again in the next IDLE.
- **Arbitration:** fixed priority by default, lowest index wins (see Configuration).

## Timing
- `req[i]` is sampled at edge k in IDLE. After edge k: `gnt[i]`=1, `spi_tx` is valid, `spi_start`=1. After edge k+1: `spi_start`=0.
- `spi_done` is sampled at edge m in WAIT. After edge m: `rsp_valid[i]`=1 with `rsp_data`. After edge m+1: `rsp_valid`=0 and `gnt`=0.
- The next grant comes earliest at edge m+2+GAP_CYCLES.
- Timeout: `rsp_valid` is asserted after the edge where the watchdog reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES WAIT cycles without `spi_done`.
- Reset asserted mid-transaction returns everything to reset values immediately, including `spi_start`=0. No response is delivered for the interrupted transaction.

## Configuration
- **`MAX30003_ARB_RR_EN` defined:** round-robin arbitration.
  - The pointer holds the index after the last winner.
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - The pointer updates when a grant is made.
- **Not defined:** fixed priority, lowest index wins. No pointer register is built.

## Test plan
- **Single transaction:** `req[1]`=1 with slice 32'h21FFFFFF; model returns `spi_done` 40 cycles after start with `spi_rx`=32'h00ABCDEF. Required: one `spi_start` pulse, `spi_tx`=32'h21FFFFFF, then `rsp_valid`=3'b010, `rsp_data`=32'h00ABCDEF, `rsp_err`=0.
- **Contention:** `req`=3'b111 held continuously.
  - Fixed priority: requester 0 wins every grant.
  - With `MAX30003_ARB_RR_EN`: grant order is 0,1,2,0.
  - In both cases grants are separated by ≥GAP_CYCLES+2 cycles.
- **Timeout:** `req[2]`=1 and `spi_done` never arrives. Required: `rsp_valid`=3'b100 with `rsp_err`=1 and `rsp_data`=0 after 4096 WAIT cycles; the arbiter returns to IDLE.
- **Boundary on `spi_done`:**
  - `spi_done` on the same cycle as the timeout: `rsp_err`=0 and data is captured.
  - A stray `spi_done` in IDLE: no response and no state change.
- **Request dropped / reset mid-transaction:**
  - `req[0]` dropped right after grant: the response is still pulsed to requester 0.
  - `rst` pulled low during WAIT: all outputs are 0 on the next cycle, and a new request after release is granted normally.
